// File: rtl/mem_resp.sv
// Single-port RAM target with a programmable wait-state delay, a one-cycle
// acknowledge and an error flag for addresses beyond the implemented depth.
`ifndef ADR_WIDTH
`define ADR_WIDTH 10
`endif

module mem_resp #(
  parameter int ADR_WIDTH   = `ADR_WIDTH,
  parameter int DAT_WIDTH   = 8,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [ADR_WIDTH-1:0] adr_i,
  input  logic [DAT_WIDTH-1:0] dat_i,
  output logic                 busy_o,
  output logic                 ack_o,
  output logic                 err_o,
  output logic [DAT_WIDTH-1:0] dat_o
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t               state;
  logic [3:0]           cnt;
  logic                 we_q;
  logic                 oor_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DAT_WIDTH-1:0] dat_q;
  logic                 access;

  logic [DAT_WIDTH-1:0] mem [MEM_DEPTH];

  // Full-width compare so addresses aliasing into the array still flag an error.
  function automatic logic out_of_range(input logic [ADR_WIDTH-1:0] a);
    return 64'(a) >= 64'(MEM_DEPTH);
  endfunction

  assign access = (state == S_WAIT) && (cnt == 4'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      we_q   <= 1'b0;
      oor_q  <= 1'b0;
      idx_q  <= '0;
      dat_q  <= '0;
      busy_o <= 1'b0;
      ack_o  <= 1'b0;
      err_o  <= 1'b0;
      dat_o  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_i) begin
            we_q   <= we_i;
            oor_q  <= out_of_range(adr_i);
            idx_q  <= adr_i[IDX_W-1:0];
            dat_q  <= dat_i;
            cnt    <= 4'(WAIT_STATES);
            busy_o <= 1'b1;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!we_q) dat_o <= oor_q ? '0 : mem[idx_q];
            ack_o <= 1'b1;
            err_o <= oor_q;
            state <= S_ACK;
          end
        end
        S_ACK: begin
          ack_o  <= 1'b0;
          err_o  <= 1'b0;
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          ack_o  <= 1'b0;
          err_o  <= 1'b0;
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  // Array has no reset; a write commits only on the WAIT->ACK edge.
  always_ff @(posedge clk_i) begin
    if (access && we_q && !oor_q) mem[idx_q] <= dat_q;
  end

endmodule

// File: tb/tb_mem_resp.sv
// Scoreboard bench for mem_resp: two instances (2 wait states with a 10-bit
// address, 0 wait states with an 8-bit address) driven by directed vectors.
module tb_mem_resp;

  localparam int WS0 = 2;
  localparam int WS1 = 0;

  typedef struct {
    int         acc;
    logic       err;
    logic [7:0] dat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req  [2];
  logic       we   [2];
  logic [9:0] adr  [2];
  logic [7:0] dat  [2];
  logic       busy [2];
  logic       ack  [2];
  logic       err  [2];
  logic [7:0] dout [2];

  exp_t q0[$];
  exp_t q1[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_resp #(.ADR_WIDTH(10), .DAT_WIDTH(8), .MEM_DEPTH(256), .WAIT_STATES(WS0)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .we_i(we[0]), .adr_i(adr[0]),
    .dat_i(dat[0]), .busy_o(busy[0]), .ack_o(ack[0]), .err_o(err[0]), .dat_o(dout[0])
  );

  mem_resp #(.ADR_WIDTH(8), .DAT_WIDTH(8), .MEM_DEPTH(256), .WAIT_STATES(WS1)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .we_i(we[1]), .adr_i(adr[1][7:0]),
    .dat_i(dat[1]), .busy_o(busy[1]), .ack_o(ack[1]), .err_o(err[1]), .dat_o(dout[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic mon(input int i);
    exp_t e;
    int   ws;
    int   sz;
    ws = (i == 0) ? WS0 : WS1;
    if (ack[i] !== 1'b1) begin
      chk($sformatf("err_without_ack%0d", i), 32'(err[i]), 32'd0);
      return;
    end
    sz = (i == 0) ? q0.size() : q1.size();
    if (sz == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_ack%0d: got ack=1 at cycle %0d want none", i, cyc);
      return;
    end
    e = (i == 0) ? q0.pop_front() : q1.pop_front();
    chk($sformatf("ack_latency%0d", i), 32'(cyc - e.acc), 32'(1 + ws));
    chk($sformatf("err%0d", i), 32'(err[i]), 32'(e.err));
    chk($sformatf("dat%0d", i), 32'(dout[i]), 32'(e.dat));
    chk($sformatf("busy_in_ack%0d", i), 32'(busy[i]), 32'd1);
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic issue(input int i, input logic w, input logic [9:0] a, input logic [7:0] d,
                       input logic e_err, input logic [7:0] e_dat);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while ((busy[i] !== 1'b0 || ack[i] !== 1'b0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL idle_timeout%0d: got busy=%0b want 0", i, busy[i]);
    end
    req[i] = 1'b1;
    we[i]  = w;
    adr[i] = a;
    dat[i] = d;
    e.acc  = cyc + 1;
    e.err  = e_err;
    e.dat  = e_dat;
    if (i == 0) q0.push_back(e); else q1.push_back(e);
    @(posedge clk);
    #1;
    req[i] = 1'b0;
  endtask

  task automatic drain(input int i);
    int n;
    n = 0;
    while (((i == 0) ? q0.size() : q1.size()) != 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL drain_timeout%0d: got %0d pending want 0", i, (i == 0) ? q0.size() : q1.size());
    end
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; adr[i] = '0; dat[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
      chk($sformatf("rst_ack%0d", i),  32'(ack[i]),  32'd0);
      chk($sformatf("rst_dat%0d", i),  32'(dout[i]), 32'd0);
    end
    rst_n = 1'b1;

    // 2 wait states: basic write/read, out-of-range accesses
    issue(0, 1'b1, 10'h003, 8'hA5, 1'b0, 8'h00);
    issue(0, 1'b0, 10'h003, 8'h00, 1'b0, 8'hA5);
    issue(0, 1'b1, 10'h0FF, 8'h33, 1'b0, 8'hA5);
    issue(0, 1'b0, 10'h100, 8'h00, 1'b1, 8'h00);
    issue(0, 1'b1, 10'h3FF, 8'h77, 1'b1, 8'h00);
    issue(0, 1'b0, 10'h0FF, 8'h00, 1'b0, 8'h33);

    // inputs changing during WAIT must not disturb the captured write
    issue(0, 1'b1, 10'h008, 8'h08, 1'b0, 8'h33);
    issue(0, 1'b1, 10'h006, 8'h06, 1'b0, 8'h33);
    issue(0, 1'b1, 10'h007, 8'h5A, 1'b0, 8'h33);
    we[0] = 1'b1; adr[0] = 10'h008; dat[0] = 8'hFF;
    @(negedge clk);
    adr[0] = 10'h006; we[0] = 1'b0; dat[0] = 8'hC3;
    drain(0);
    issue(0, 1'b0, 10'h007, 8'h00, 1'b0, 8'h5A);
    issue(0, 1'b0, 10'h008, 8'h00, 1'b0, 8'h08);
    issue(0, 1'b0, 10'h006, 8'h00, 1'b0, 8'h06);

    // reset mid-cycle during WAIT of a write, with req held high
    issue(0, 1'b1, 10'h009, 8'h22, 1'b0, 8'h06);
    issue(0, 1'b0, 10'h009, 8'h00, 1'b0, 8'h22);
    issue(0, 1'b1, 10'h009, 8'hEE, 1'b0, 8'h22);
    req[0] = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy[0]), 32'd0);
    chk("async_rst_ack",  32'(ack[0]),  32'd0);
    chk("async_rst_err",  32'(err[0]),  32'd0);
    chk("async_rst_dat",  32'(dout[0]), 32'd0);
    q0.delete();
    req[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    issue(0, 1'b0, 10'h009, 8'h00, 1'b0, 8'h22);
    drain(0);

    // 0 wait states: single accesses, then a continuously held read
    issue(1, 1'b1, 10'h000, 8'h11, 1'b0, 8'h00);
    issue(1, 1'b0, 10'h000, 8'h00, 1'b0, 8'h11);
    drain(1);
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; adr[1] = 10'h000;
    k = cyc + 1;
    for (int j = 0; j < 3; j++) begin
      exp_t e;
      e.acc = k + 3 * j;
      e.err = 1'b0;
      e.dat = 8'h11;
      q1.push_back(e);
    end
    drain(1);
    req[1] = 1'b0;
    issue(1, 1'b1, 10'h005, 8'hAB, 1'b0, 8'h11);
    issue(1, 1'b0, 10'h005, 8'h00, 1'b0, 8'hAB);
    drain(1);
    repeat (6) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_resp.md
# mem_resp

Memory responder at the far end of the CPU address path: accepts single read/write requests carrying the address presented by the address unit, inserts a programmable number of wait states, then completes the access with a one-cycle acknowledge. Contains the backing word array and signals an error for addresses beyond the implemented depth. Sits between the core's address/data unit and the memory map as the only on-chip RAM target.

## Interface
- ADR_WIDTH, `ADR_WIDTH: width of adr_i.
- DAT_WIDTH, 8: width of data words.
- MEM_DEPTH, 256: implemented words, 1..2**ADR_WIDTH; addresses >= MEM_DEPTH are out of range.
- WAIT_STATES, 2: extra cycles before completion, 0..15.

- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  asynchronous, active-low reset (one clock; polarity and asynchronous behaviour are fixed).
- req_i  in  1  request strobe; sampled only in IDLE.
- we_i  in  1  1 = write, 0 = read; sampled with req_i.
- adr_i  in  ADR_WIDTH  word address; sampled with req_i.
- dat_i  in  DAT_WIDTH  write data; sampled with req_i.
- busy_o  out  1  high from acceptance until the ACK cycle ends (inclusive).
- ack_o  out  1  one-cycle completion pulse.
- err_o  out  1  valid only with ack_o; high if the accepted address was out of range.
- dat_o  out  DAT_WIDTH  read data; registered, holds its value between reads.

## Operation
- States: IDLE, WAIT, ACK. Two-bit encoded state register plus a 4-bit wait counter.
- IDLE: busy_o=0, ack_o=0. If req_i=1 at an edge: capture we_i, adr_i, dat_i into request registers; compute range flag (adr_i >= MEM_DEPTH, full ADR_WIDTH compare); load counter = WAIT_STATES; go to WAIT.
- WAIT: busy_o=1. If counter != 0: decrement, stay. If counter == 0: perform access at this edge, go to ACK.
- Access (WAIT->ACK edge): in range write -> array[adr] <= captured data, dat_o unchanged. In range read -> dat_o <= array[adr]. Out of range: no array access, dat_o <= 0 for reads, unchanged for writes; err flag registered.
- ACK: ack_o=1, busy_o=1, err_o = range flag; unconditionally go to IDLE next edge. req_i ignored in WAIT and ACK; requester holds or re-issues; a request held through ACK is accepted again in the following IDLE cycle (no automatic drop).
- Array contents not reset; reading an unwritten word returns undefined data.
- Only the captured copies of we/adr/dat are used after acceptance; input changes during WAIT have no effect.

## Timing
- Reset (rst_ni low, asynchronous, any state): state=IDLE, counter=0, busy_o=0, ack_o=0, err_o=0, dat_o=0, request registers=0. An in-flight request is dropped; its write is never committed unless the WAIT->ACK edge occurred before reset assertion.
- Acceptance at edge k -> ack_o high in the cycle after edge k+1+WAIT_STATES; exactly one cycle wide.
- WAIT_STATES=0: ack_o after edge k+1. Back-to-back throughput: one access per WAIT_STATES+3 cycles.
- dat_o valid in the ACK cycle and holds until the next completed read or reset.
- err_o is 0 whenever ack_o is 0.
- Counter never wraps: loaded only in IDLE, decremented only while nonzero.

## Test plan
- Reset: drive rst_ni low mid-cycle with req_i=1 -> outputs 0 immediately, no ack after release until a new request.
- Write 0xA5 to adr 3, then read adr 3 with WAIT_STATES=2 -> each ack_o pulse one cycle, 3 edges after acceptance; read dat_o=0xA5, err_o=0.
- WAIT_STATES=0 write 0x11 adr 0, read adr 0 -> ack after 1 edge, dat_o=0x11; req_i held high continuously -> acks every 3 cycles.
- MEM_DEPTH=256, ADR_WIDTH=10: read adr 0x100 -> ack with err_o=1, dat_o=0x00; write adr 0x3FF data 0x77 -> err_o=1, array adr 0xFF unchanged.
- Change adr_i/dat_i/we_i during WAIT after accepted write of 0x5A to adr 7 -> adr 7 holds 0x5A, no other word modified.
- Assert reset during WAIT of a write 0xEE to adr 9 (previously 0x22) -> after reset, read adr 9 returns 0x22.
